// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, credit-limited imem requests, in-order buffer
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [0:0]  BOOT  = 1'b0;
    localparam logic [0:0]  FETCH = 1'b1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [0:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   buf_data [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];
    logic [CW:0]   inflight;
    logic [31:0]   redirect_aligned;
    logic          accept;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
    assign inflight         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid   = (state == FETCH) && !redirect_valid && (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr    = fetch_pc;
    assign accept           = imem_req_valid && imem_req_ready;
    assign push             = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign instr_valid      = (count != '0);
    assign pop              = instr_valid && instr_ready && !redirect_valid;
    assign redirect_aligned = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state <= FETCH;
            if (redirect_valid) begin
                // Every request still outstanding after this cycle is wrong-path.
                fetch_pc    <= redirect_aligned;
                rsp_pc      <= redirect_aligned;
                count       <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                outstanding <= outstanding - CW'(imem_rsp_valid);
                drop_cnt    <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push) begin
                    wr_ptr <= ptr_next(wr_ptr);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= ptr_next(rd_ptr);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_rsp_data;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
    end

    assign instr          = instr_valid ? buf_data[rd_ptr] : NOP;
    assign instr_pc       = instr_valid ? buf_pc[rd_ptr] : 32'h0;
    assign instr_pc_plus4 = instr_pc + 32'd4;
    assign op             = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7         = instr[31:25];
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit with a variable-latency imem model
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int npop = 0;
    int exp_drop;
    logic found;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] exp_q     [$];
    logic [31:0] acc_log   [$];

    fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
        .op(op), .funct3(funct3), .funct7(funct7)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
    endfunction

    // Memory model: returns words in order, no earlier than lat cycles after accept.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            imem_rsp_valid = 1'b0;
            pend_addr.delete();
            pend_due.delete();
        end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
    end

    // Scoreboard: accepted addresses are expected in order at the decode side.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_log.delete();
        end else begin
            if (redirect_valid) begin
                exp_q.delete();
            end else if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pop", instr_pc, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    logic [31:0] w;
                    e = exp_q.pop_front();
                    w = word_of(e);
                    npop++;
                    chk("sb_pc", instr_pc, e);
                    chk("sb_instr", instr, w);
                    chk("sb_op", {25'h0, op}, {25'h0, w[6:0]});
                    chk("sb_funct3", {29'h0, funct3}, {29'h0, w[14:12]});
                    chk("sb_funct7", {25'h0, funct7}, {25'h0, w[31:25]});
                    chk("sb_pc_plus4", instr_pc_plus4, e + 32'd4);
                end
            end
            if (!instr_valid) begin
                chk("idle_nop", instr, NOP);
                chk("idle_pc", instr_pc, 32'h0);
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
                exp_q.push_back(imem_req_addr);
                acc_log.push_back(imem_req_addr);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        chk({tag, "_req_addr"}, imem_req_addr, RPC);
        chk({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'h0);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    endtask

    // Called at a drive point; expected drop count is what the memory still owes us.
    task automatic do_redirect(input logic [31:0] pc);
        exp_drop       = pend_addr.size();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        acc_log.delete();
        @(negedge clk);
        chk("redir_no_req", {31'h0, imem_req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_drop_cnt", 32'(dut.drop_cnt), 32'(exp_drop));
        chk("redir_fifo_empty", {31'h0, instr_valid}, 32'h0);
        chk("redir_next_addr", imem_req_addr, pc & ~32'h3);
    endtask

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_no_req", {31'h0, imem_req_valid}, 32'h0);
        tick();
        @(negedge clk);
        chk("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("first_req_addr", imem_req_addr, RPC);
        repeat (12) tick();
        chk("seq_addr0", acc_at(0), 32'h100);
        chk("seq_addr1", acc_at(1), 32'h104);
        chk("seq_addr2", acc_at(2), 32'h108);
        chk("seq_pops", {31'h0, npop >= 3}, 32'h1);

        // Decode stalls: exactly DEPTH new-path accepts, then requests stop.
        tick();
        instr_ready = 1'b0;
        do_redirect(32'h300);
        repeat (9) tick();
        @(negedge clk);
        chk("stall_accepts", acc_log.size(), 32'd2);
        chk("stall_req_off", {31'h0, imem_req_valid}, 32'h0);
        chk("stall_full", {31'h0, instr_valid}, 32'h1);
        tick();
        instr_ready = 1'b1;
        @(negedge clk);
        chk("drain_pop0", instr_pc, 32'h300);
        tick();
        @(negedge clk);
        chk("drain_pop1", instr_pc, 32'h304);

        // Redirect with two wrong-path requests in flight.
        lat = 4;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pend_addr.size() == 2 && !imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("two_inflight_found", {31'h0, found}, 32'h1);
        do_redirect(32'h203);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("redir_first_valid", {31'h0, found}, 32'h1);
        chk("redir_first_pc", instr_pc, 32'h200);

        // Redirect coinciding with a response and a consume.
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (imem_rsp_valid && instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("rsp_pop_coincide_found", {31'h0, found}, 32'h1);
        do_redirect(32'h400);

        // PC wrap at the top of the address space.
        tick();
        do_redirect(32'hFFFF_FFF8);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == 32'hFFFF_FFFC) begin
                found = 1'b1;
                break;
            end
        end
        chk("wrap_found", {31'h0, found}, 32'h1);
        chk("wrap_plus4", instr_pc_plus4, 32'h0);
        repeat (6) tick();
        chk("wrap_addr0", acc_at(0), 32'hFFFF_FFF8);
        chk("wrap_addr1", acc_at(1), 32'hFFFF_FFFC);
        chk("wrap_addr2", acc_at(2), 32'h0000_0000);

        // Asynchronous reset in the middle of a burst.
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_boot_no_req", {31'h0, imem_req_valid}, 32'h0);
        tick();
        @(negedge clk);
        chk("midrst_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("midrst_req_addr", imem_req_addr, RPC);
        repeat (8) tick();

        // Stop fetching and drain: nothing accepted may be lost.
        imem_req_ready = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        chk("drain_sb_empty", exp_q.size(), 32'd0);
        chk("drain_fifo_empty", {31'h0, instr_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
